// File: rtl/mas16_pkg.sv
// rtl/mas16_pkg.sv - shared widths, fetch entry type and PC helper for the 16-bit core
package mas16_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

  // PC arithmetic is modulo 2^ADDR_W; odd PCs are legal and advance unchanged in parity.
  function automatic logic [ADDR_W-1:0] advancePc(input logic [ADDR_W-1:0] pc, input int step);
    return pc + ADDR_W'(step);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two FIFO with flush; head is read straight from storage
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wrData,
  output logic [WIDTH-1:0] rdData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop & ~flush & ~empty;
  // A pop frees the slot this edge, so a full queue may still accept a push.
  assign doPush = push & ~flush & (~full | doPop);
  assign rdData = storage[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        storage[wrPtr] <= wrData;
        wrPtr          <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      if (doPush && !doPop) begin
        count <= count + CNT_W'(1);
      end else if (doPop && !doPush) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_queue_16b.sv
// rtl/fetch_queue_16b.sv - instruction fetch front end: PC, memory port A, prefetch queue, redirect
module fetch_queue_16b
  import mas16_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                PC_STEP  = 2,
  localparam int               OCC_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetchEnable,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [WORD_W-1:0] memData,
  output logic              instrValid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instrPC,
  input  logic              instrReady,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPC,
  output logic [OCC_W-1:0]  occupancy,
  inout  wire               dvdd,
  inout  wire               dgnd
);

  logic [ADDR_W-1:0] fetchPC;
  fetch_entry_t      wrEntry;
  fetch_entry_t      headEntry;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              push;
  logic              pop;

  wire unusedSupply = dvdd ^ dgnd;

  // Address comes only from the register so a same-cycle port B write is seen at capture.
  assign memAddr    = fetchPC;
  assign instrValid = ~fifoEmpty;
  assign pop        = instrValid & instrReady;
  assign push       = fetchEnable & ~redirect & (~fifoFull | pop);

  assign wrEntry.pc   = fetchPC;
  assign wrEntry.word = memData;
  assign instr        = headEntry.word;
  assign instrPC      = headEntry.pc;

  // Redirect flushes the queue; the fifo also drops any pop offered alongside it.
  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) uQueue (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect),
    .wrData (wrEntry),
    .rdData (headEntry),
    .count  (occupancy),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPC <= RESET_PC;
    end else if (redirect) begin
      fetchPC <= redirectPC;
    end else if (push) begin
      fetchPC <= advancePc(fetchPC, PC_STEP);
    end
  end

endmodule

// File: tb/tb_fetch_queue_16b.sv
// tb/tb_fetch_queue_16b.sv - scoreboard bench with behavioural fetch model and directed scenarios
module tb_fetch_queue_16b;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetchEnable;
  logic [15:0] memAddr;
  logic [15:0] memData;
  logic        instrValid;
  logic [15:0] instr;
  logic [15:0] instrPC;
  logic        instrReady;
  logic        redirect;
  logic [15:0] redirectPC;
  logic [2:0]  occupancy;
  wire         dvdd = 1'b1;
  wire         dgnd = 1'b0;

  logic [7:0]  mem [65536];
  logic [31:0] expQ [$];
  logic [15:0] modelPC = 16'h0000;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign memData = {mem[memAddr], mem[memAddr + 16'd1]};

  fetch_queue_16b #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetchEnable(fetchEnable),
    .memAddr    (memAddr),
    .memData    (memData),
    .instrValid (instrValid),
    .instr      (instr),
    .instrPC    (instrPC),
    .instrReady (instrReady),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .occupancy  (occupancy),
    .dvdd       (dvdd),
    .dgnd       (dgnd)
  );

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {mem[a], mem[a + 16'd1]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    modelPC = 16'h0000;
  endtask

  // Reference: a list of fetched-but-unconsumed {pc,word} plus the next PC to fetch.
  task automatic modelStep();
    bit doPop;
    bit doPush;
    if (redirect) begin
      expQ.delete();
      modelPC = redirectPC;
    end else begin
      doPop  = (expQ.size() > 0) && instrReady;
      doPush = fetchEnable && ((expQ.size() < DEPTH) || doPop);
      if (doPop) void'(expQ.pop_front());
      if (doPush) begin
        expQ.push_back({modelPC, memWord(modelPC)});
        modelPC = modelPC + 16'd2;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1) modelStep();
    end
  end

  // Monitor: compares what the DUT presents against the head of the expected list.
  initial begin
    forever begin
      @(negedge clk);
      chk("mon_valid", {31'd0, instrValid}, {31'd0, expQ.size() > 0});
      chk("mon_occupancy", {29'd0, occupancy}, expQ.size());
      chk("mon_memAddr", {16'd0, memAddr}, {16'd0, modelPC});
      if (expQ.size() > 0) begin
        chk("mon_head", {instrPC, instr}, expQ[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  occTab  [6];
    logic [15:0] addrTab [6];
    occTab  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    addrTab = '{16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0008, 16'h0008};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
    mem[16'h0100] = 8'hA5; mem[16'h0101] = 8'h5A;
    mem[16'hFFFF] = 8'h77;
    mem[16'h0040] = 8'h00; mem[16'h0041] = 8'h00;

    rst_n = 1'b0; fetchEnable = 1'b0; instrReady = 1'b0;
    redirect = 1'b0; redirectPC = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, instrValid}, 32'd0);
    chk("reset_instr", {16'd0, instr}, 32'd0);
    chk("reset_pc", {16'd0, instrPC}, 32'd0);
    chk("reset_occ", {29'd0, occupancy}, 32'd0);
    chk("reset_memAddr", {16'd0, memAddr}, 32'd0);

    // Streaming fetch from reset
    fetchEnable = 1'b1; instrReady = 1'b1; rst_n = 1'b1;
    step();
    chk("fetch0", {instrPC, instr}, 32'h0000_1234);
    chk("fetch0_addr", {16'd0, memAddr}, 32'h0002);
    step();
    chk("fetch1", {instrPC, instr}, 32'h0002_5678);
    chk("fetch1_addr", {16'd0, memAddr}, 32'h0004);
    step();
    chk("fetch2", {instrPC, instr}, 32'h0004_9ABC);
    chk("fetch2_addr", {16'd0, memAddr}, 32'h0006);

    // Backpressure from a fresh reset
    rst_n = 1'b0; instrReady = 1'b0; modelReset();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_occ", {29'd0, occupancy}, {29'd0, occTab[i]});
      chk("bp_addr", {16'd0, memAddr}, {16'd0, addrTab[i]});
      chk("bp_head", {instrPC, instr}, 32'h0000_1234);
    end
    instrReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fullpop_occ", {29'd0, occupancy}, 32'd4);
      chk("fullpop_pc", {16'd0, instrPC}, 2 * (i + 1));
    end

    // Redirect with three entries held and a concurrent pop
    fetchEnable = 1'b0;
    step();
    chk("redir_pre_occ", {29'd0, occupancy}, 32'd3);
    fetchEnable = 1'b1; redirect = 1'b1; redirectPC = 16'h0100;
    step();
    redirect = 1'b0;
    chk("redir_occ", {29'd0, occupancy}, 32'd0);
    chk("redir_valid", {31'd0, instrValid}, 32'd0);
    chk("redir_addr", {16'd0, memAddr}, 32'h0100);
    step();
    chk("redir_head", {instrPC, instr}, 32'h0100_A55A);

    // Wrap at the top of the address space
    redirect = 1'b1; redirectPC = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", {16'd0, memAddr}, 32'hFFFE);
    step();
    chk("wrap_pc0", {16'd0, instrPC}, 32'hFFFE);
    chk("wrap_addr1", {16'd0, memAddr}, 32'h0000);
    step();
    chk("wrap_pc1", {16'd0, instrPC}, 32'h0000);
    chk("wrap_addr2", {16'd0, memAddr}, 32'h0002);
    step();
    chk("wrap_pc2", {16'd0, instrPC}, 32'h0002);

    redirect = 1'b1; redirectPC = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("odd_addr", {16'd0, memAddr}, 32'hFFFF);
    step();
    chk("odd_head", {instrPC, instr}, 32'hFFFF_7712);
    chk("odd_next", {16'd0, memAddr}, 32'h0001);

    // Asynchronous reset between edges with three entries queued
    instrReady = 1'b0; redirect = 1'b1; redirectPC = 16'h0200;
    step();
    redirect = 1'b0;
    repeat (3) step();
    chk("arst_pre_occ", {29'd0, occupancy}, 32'd3);
    #2;
    rst_n = 1'b0; modelReset();
    #1;
    chk("arst_valid", {31'd0, instrValid}, 32'd0);
    chk("arst_occ", {29'd0, occupancy}, 32'd0);
    chk("arst_addr", {16'd0, memAddr}, 32'h0000);
    step();
    rst_n = 1'b1; instrReady = 1'b1;
    step();
    chk("arst_restart", {instrPC, instr}, 32'h0000_1234);

    // Port B write on the negedge of the fetch cycle
    redirect = 1'b1; redirectPC = 16'h0040;
    step();
    redirect = 1'b0;
    chk("wtf_addr", {16'd0, memAddr}, 32'h0040);
    @(negedge clk);
    mem[16'h0040] = 8'hBE; mem[16'h0041] = 8'hEF;
    step();
    chk("wtf_head", {instrPC, instr}, 32'h0040_BEEF);

    // Randomized traffic checked by the monitor against the model
    for (int n = 0; n < 400; n++) begin
      fetchEnable = ($urandom_range(0, 3) != 0);
      instrReady  = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirectPC  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                : 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 0) mem[modelPC] = 8'($urandom);
        else mem[16'($urandom)] = 8'($urandom);
      end
      step();
    end
    redirect = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
